// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: address width, reset vector and the
// fetch-buffer entry pairing an instruction with its PC.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bundle: instruction-memory request/response, decode-side
// instruction handshake, and redirect/halt control.
interface ifu_if #(
  parameter int unsigned XLEN = cpu_pkg::XLEN
) ();
  import cpu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [ILEN-1:0] resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc,
    input  req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc,
    output req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc, halt
  );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: circular FIFO of fetch entries with a one-cycle flush and
// a head that reads straight out of storage.
module fetch_fifo import cpu_pkg::*; #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  entry_t                       push_data,
  input  logic                         pop,
  output entry_t                       head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: credit-limited sequential fetch into a small
// buffer, with redirect flush and discard of stale in-flight responses.
module ifu import cpu_pkg::*; #(
  parameter int unsigned     XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int unsigned     DEPTH    = 4
) (
  input logic  clk,
  input logic  rst,
  ifu_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] tgt_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic            credit_ok;
  logic            req_fire;
  logic            push;
  logic            pop;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // Requests in flight plus buffered entries never exceed the buffer size,
  // so every kept response is guaranteed a slot.
  assign credit_ok = (SW'(outstanding) + SW'(count)) < SW'(DEPTH);

  assign bus.req_valid  = !rst && !bus.halt && !bus.redirect_valid && credit_ok;
  assign bus.req_addr   = fetch_pc;
  assign req_fire       = bus.req_valid && bus.req_ready;

  assign bus.inst_valid = (count != '0);
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;
  assign pop            = bus.inst_valid && bus.inst_ready;

  assign push      = bus.resp_valid && !bus.redirect_valid && (drop_cnt == '0);
  assign push_data = '{pc: resp_pc, inst: bus.resp_data};
  assign tgt_pc    = {bus.redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    outstanding_nxt = outstanding;
    if (req_fire && !bus.resp_valid)      outstanding_nxt = outstanding + CW'(1);
    else if (!req_fire && bus.resp_valid) outstanding_nxt = outstanding - CW'(1);
  end

  // On redirect every remaining in-flight response belongs to the old path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect_valid) begin
        fetch_pc <= tgt_pc;
        resp_pc  <= tgt_pc;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (bus.resp_valid) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
          else                resp_pc  <= resp_pc + XLEN'(4);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed vector table, async-reset sequence, then
// randomized traffic against a queue-based reference model.
module tb_ifu;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  ifu_if #(.XLEN(32)) bus ();

  ifu #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rr;
    logic        rv;
    logic [31:0] rdata;
    logic        ir;
    logic        rd;
    logic [31:0] rpc;
    logic        h;
    logic        erv;
    logic [31:0] eaddr;
    logic        eiv;
    logic [31:0] epc;
    logic [31:0] einst;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  vec_t    tbl [22];
  flight_t fl_q [$];
  entry_t  fb_q [$];
  logic [31:0] m_pc;
  bit      halt_r;
  bit      prev_rd;

  function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rdata,
                              input logic ir, input logic rd, input logic [31:0] rpc, input logic h,
                              input logic erv, input logic [31:0] eaddr, input logic eiv,
                              input logic [31:0] epc, input logic [31:0] einst);
    vec_t v;
    v.rr = rr; v.rv = rv; v.rdata = rdata; v.ir = ir; v.rd = rd; v.rpc = rpc; v.h = h;
    v.erv = erv; v.eaddr = eaddr; v.eiv = eiv; v.epc = epc; v.einst = einst;
    return v;
  endfunction

  function automatic logic [31:0] a(input logic [31:0] off);
    return RST_PC + off;
  endfunction

  function automatic logic [31:0] dv(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] data_of(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check1(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rr, input logic rv, input logic [31:0] rdata, input logic ir,
                       input logic rd, input logic [31:0] rpc, input logic h);
    bus.req_ready      = rr;
    bus.resp_valid     = rv;
    bus.resp_data      = rdata;
    bus.inst_ready     = ir;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    bus.halt           = h;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    fl_q.delete();
    fb_q.delete();
    m_pc    = RST_PC;
    halt_r  = 1'b0;
    prev_rd = 1'b0;
    repeat (2) @(negedge clk);
    check1("rst_req_valid", bus.req_valid, 1'b0);
    check1("rst_inst_valid", bus.inst_valid, 1'b0);
    rst = 1'b0;
  endtask

  // Reference model: one queue of in-flight requests (with a stale mark)
  // and one queue of buffered instructions.
  task automatic run_random(input int n, input bit full);
    logic        rr, rv, ir, rd;
    logic [31:0] rdata, rpc;
    logic        exp_rv, exp_iv;
    flight_t     f;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rr = full ? 1'b1 : ($urandom_range(0, 3) != 0);
      rv = (fl_q.size() != 0) && (fl_q[0].due <= cyc) && (full || ($urandom_range(0, 2) != 0));
      rdata = rv ? data_of(fl_q[0].addr) : $urandom;
      ir = full ? 1'b1 : ($urandom_range(0, 2) != 0);
      rd = !full && !prev_rd && ($urandom_range(0, 19) == 0);
      rpc = RST_PC + $urandom_range(0, 4095);
      if (!full && $urandom_range(0, 24) == 0) halt_r = !halt_r;
      drive(rr, rv, rdata, ir, rd, rpc, halt_r);
      #1;
      exp_rv = !halt_r && !rd && ((fl_q.size() + fb_q.size()) < DEPTH);
      exp_iv = (fb_q.size() != 0);
      check1("rnd_req_valid", bus.req_valid, exp_rv);
      if (exp_rv) check32("rnd_req_addr", bus.req_addr, m_pc);
      check1("rnd_inst_valid", bus.inst_valid, exp_iv);
      if (exp_iv) begin
        check32("rnd_inst_pc", bus.inst_pc, fb_q[0].pc);
        check32("rnd_inst", bus.inst, fb_q[0].inst);
      end
      f = '{addr: 32'h0, stale: 1'b1, due: 0};
      if (rv) f = fl_q.pop_front();
      if (exp_iv && ir) void'(fb_q.pop_front());
      if (rd) begin
        fb_q.delete();
        foreach (fl_q[i]) fl_q[i].stale = 1'b1;
        m_pc = {rpc[31:2], 2'b00};
      end else begin
        if (rv && !f.stale) fb_q.push_back('{pc: f.addr, inst: rdata});
        if (exp_rv && rr) begin
          fl_q.push_back('{addr: m_pc, stale: 1'b0, due: cyc + 1 + (full ? 0 : int'($urandom_range(0, 3)))});
          m_pc = m_pc + 32'd4;
        end
      end
      prev_rd = rd;
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    tbl[0]  = mk(1,0,0,     0,0,0,       0, 1,a(32'h000),0,0,0);
    tbl[1]  = mk(1,1,dv(0), 0,0,0,       0, 1,a(32'h004),0,0,0);
    tbl[2]  = mk(1,1,dv(1), 0,0,0,       0, 1,a(32'h008),1,a(32'h000),dv(0));
    tbl[3]  = mk(1,0,0,     0,0,0,       0, 1,a(32'h00C),1,a(32'h000),dv(0));
    tbl[4]  = mk(1,0,0,     0,0,0,       0, 0,0,         1,a(32'h000),dv(0));
    tbl[5]  = mk(1,1,dv(2), 0,0,0,       1, 0,0,         1,a(32'h000),dv(0));
    tbl[6]  = mk(1,0,0,     1,0,0,       1, 0,0,         1,a(32'h000),dv(0));
    tbl[7]  = mk(1,0,0,     0,0,0,       1, 0,0,         1,a(32'h004),dv(1));
    tbl[8]  = mk(1,1,dv(3), 1,1,a(32'h103),0, 0,0,       1,a(32'h004),dv(1));
    tbl[9]  = mk(0,0,0,     0,0,0,       0, 1,a(32'h100),0,0,0);
    tbl[10] = mk(1,0,0,     0,0,0,       0, 1,a(32'h100),0,0,0);
    tbl[11] = mk(1,1,dv(4), 0,0,0,       0, 1,a(32'h104),0,0,0);
    tbl[12] = mk(0,0,0,     1,0,0,       0, 1,a(32'h108),1,a(32'h100),dv(4));
    tbl[13] = mk(0,1,dv(5), 0,0,0,       0, 1,a(32'h108),0,0,0);
    tbl[14] = mk(0,0,0,     0,0,0,       0, 1,a(32'h108),1,a(32'h104),dv(5));
    tbl[15] = mk(1,0,0,     1,0,0,       0, 1,a(32'h108),1,a(32'h104),dv(5));
    tbl[16] = mk(1,0,0,     0,0,0,       0, 1,a(32'h10C),0,0,0);
    tbl[17] = mk(0,0,0,     0,1,a(32'h202),0, 0,0,       0,0,0);
    tbl[18] = mk(1,1,dv(6), 0,0,0,       0, 1,a(32'h200),0,0,0);
    tbl[19] = mk(0,1,dv(7), 0,0,0,       0, 1,a(32'h204),0,0,0);
    tbl[20] = mk(0,1,dv(8), 0,0,0,       0, 1,a(32'h204),0,0,0);
    tbl[21] = mk(0,0,0,     0,0,0,       0, 1,a(32'h204),1,a(32'h200),dv(8));

    do_reset();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i].rr, tbl[i].rv, tbl[i].rdata, tbl[i].ir, tbl[i].rd, tbl[i].rpc, tbl[i].h);
      #1;
      check1($sformatf("v%0d_req_valid", i), bus.req_valid, tbl[i].erv);
      if (tbl[i].erv) check32($sformatf("v%0d_req_addr", i), bus.req_addr, tbl[i].eaddr);
      check1($sformatf("v%0d_inst_valid", i), bus.inst_valid, tbl[i].eiv);
      if (tbl[i].eiv) begin
        check32($sformatf("v%0d_inst_pc", i), bus.inst_pc, tbl[i].epc);
        check32($sformatf("v%0d_inst", i), bus.inst, tbl[i].einst);
      end
    end

    // Asynchronous reset between edges must drop both valids at once.
    @(posedge clk);
    #2;
    check1("pre_arst_inst_valid", bus.inst_valid, 1'b1);
    check1("pre_arst_req_valid", bus.req_valid, 1'b1);
    rst = 1'b1;
    #1;
    check1("arst_req_valid", bus.req_valid, 1'b0);
    check1("arst_inst_valid", bus.inst_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check1("arst_restart_valid", bus.req_valid, 1'b1);
    check32("arst_restart_addr", bus.req_addr, RST_PC);
    check1("arst_restart_inst_valid", bus.inst_valid, 1'b0);

    do_reset();
    run_random(40, 1'b1);
    do_reset();
    run_random(4000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter XLEN, default 32, address/data width of PC and instruction.
REQ-002 Parameter RESET_PC, default 32'h80000000, first fetch address after reset.
REQ-003 Parameter DEPTH, default 4, fetch-buffer entries and maximum in-flight requests; legal range 2..16.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  out  1  instruction-memory request valid.
REQ-007 req_ready  in  1  memory accepts request this cycle.
REQ-008 req_addr  out  XLEN  fetch address, word aligned.
REQ-009 resp_valid  in  1  read data returning; in order, always accepted, at least 1 cycle after its request handshake.
REQ-010 resp_data  in  32  fetched instruction word.
REQ-011 inst_valid  out  1  buffered instruction available to decode.
REQ-012 inst_ready  in  1  decode consumes head this cycle.
REQ-013 inst  out  32  head instruction.
REQ-014 inst_pc  out  XLEN  PC of head instruction.
REQ-015 redirect_valid  in  1  branch/jump/trap redirect, single-cycle pulse.
REQ-016 redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored and treated as 0.
REQ-017 halt  in  1  level; suppresses new requests (ebreak stop).

Function
REQ-018 State: fetch_pc (next issue address), resp_pc (PC of next kept response), outstanding (requests handshaked, response not yet seen), drop_cnt (responses still to discard), FIFO of {pc, inst} pairs, count.
REQ-019 req_valid = !halt && !redirect_valid && (outstanding + count < DEPTH); req_addr = fetch_pc.
REQ-020 Request handshake (req_valid && req_ready): fetch_pc += 4, outstanding += 1; XLEN-bit wrap-around from all-ones to 0 is permitted.
REQ-021 Response with drop_cnt > 0: discarded, drop_cnt -= 1, outstanding -= 1, no FIFO write.
REQ-022 Response with drop_cnt == 0 and no redirect: FIFO push {resp_pc, resp_data}, resp_pc += 4, outstanding -= 1.
REQ-023 Simultaneous request and response in one cycle: outstanding unchanged.
REQ-024 inst_valid = (count != 0); inst/inst_pc from FIFO head, zero-latency (combinational from storage); dequeue on inst_valid && inst_ready.
REQ-025 Simultaneous push and pop: count unchanged; push into full FIFO cannot occur by REQ-019 credit rule.
REQ-026 Redirect cycle: FIFO flushed (count <= 0), fetch_pc <= resp_pc <= {redirect_pc[XLEN-1:2],2'b00}, any response in that cycle discarded, drop_cnt <= outstanding - resp_valid, outstanding <= outstanding - resp_valid.
REQ-027 Dequeue handshake in redirect cycle counts as delivered to decode; flush still applies.
REQ-028 Redirect while drop_cnt > 0: drop_cnt recomputed per REQ-026 (covers all in-flight).
REQ-029 First request to new target issued the cycle after redirect, credit permitting; response to a new-target request is never dropped.
REQ-030 halt: outstanding responses still complete and enter FIFO; requests resume the cycle after halt deasserts.
REQ-031 Latency: reset release to first req_valid = 1 cycle; response to inst_valid = 1 cycle.

Reset
REQ-032 On rst: fetch_pc = resp_pc = RESET_PC, outstanding = drop_cnt = count = 0, FIFO pointers 0, inst_valid = 0; req_valid low during rst.
REQ-033 Reset mid-transaction abandons all in-flight responses; memory side is reset concurrently and returns none after rst.

Structure
REQ-034 Shared package cpu_pkg holds XLEN, RESET_PC, instruction-width constant and a fetch-entry struct {pc, inst}.
REQ-035 One sub-module fetch_fifo (parametrised DEPTH, entry type, flush input); counters and PC logic in ifu.
REQ-036 Counters sized $clog2(DEPTH+1) bits.

Verification
REQ-037 Reset release, req_ready=1, 1-cycle memory, inst_ready=1 -> req_addr 0x80000000, 0x80000004, ...; inst_pc sequence identical, one instruction per cycle after fill.
REQ-038 inst_ready=0, DEPTH=4 -> exactly 4 requests issued, then req_valid=0; raising inst_ready delivers PCs 0x80000000..0x8000000C in order.
REQ-039 3 requests in flight, redirect_pc=0x80000103 -> next req_addr 0x80000100, 3 old responses discarded, first inst_pc 0x80000100.
REQ-040 Redirect in same cycle as response and as dequeue -> response dropped, drop_cnt = outstanding-1, FIFO empty next cycle.
REQ-041 halt=1 with 2 outstanding -> no new req_valid, both responses appear on inst; halt=0 -> fetch resumes at following address.
REQ-042 Async rst asserted mid-stream between clock edges -> req_valid and inst_valid drop immediately; restart fetch at 0x80000000.
